// File: rtl/ccc_lock_reset_seq_if.sv
// Control/status bundle between MSS firmware (master) and the CCC lock reset sequencer (slave).
// SOFT_RST and CLR_STATUS are level-sampled single-cycle strobes on FAB_CLK; there is no valid/ready pair on this block.
interface ccc_lock_reset_seq_if #(
  parameter int CNT_W = 8
);
  logic             FAB_LOCK;
  logic             MSS_LOCK;
  logic             SOFT_RST;
  logic             CLR_STATUS;
  logic             FAB_RST_N;
  logic             CLK_READY;
  logic             LOCK_LOST;
  logic [CNT_W-1:0] LOSS_CNT;
  logic [1:0]       DBG_STATE;

  modport master (
    output FAB_LOCK, MSS_LOCK, SOFT_RST, CLR_STATUS,
    input  FAB_RST_N, CLK_READY, LOCK_LOST, LOSS_CNT, DBG_STATE
  );

  modport slave (
    input  FAB_LOCK, MSS_LOCK, SOFT_RST, CLR_STATUS,
    output FAB_RST_N, CLK_READY, LOCK_LOST, LOSS_CNT, DBG_STATE
  );
endinterface

// File: rtl/ccc_lock_reset_seq.sv
// Sequences the fabric reset from the CCC lock outputs: HOLD -> WAIT -> SETTLE -> RUN, with sticky loss status.
// Optional feature macro CCC_LOCK_GLITCH_FILTER_EN: in RUN, only GLITCH_CYCLES consecutive low lock cycles count as loss.
module ccc_lock_reset_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int MIN_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
`ifdef CCC_LOCK_GLITCH_FILTER_EN
  parameter int GLITCH_CYCLES      = 4,
`endif
  parameter int CNT_W              = 8
) (
  input logic                 FAB_CLK,
  input logic                 M2F_RESET_N,
  ccc_lock_reset_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  localparam int SEQ_MAX = (MIN_RST_CYCLES > LOCK_STABLE_CYCLES) ? MIN_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam logic [SEQ_W-1:0] HOLD_LAST   = SEQ_W'(MIN_RST_CYCLES - 1);
  localparam logic [SEQ_W-1:0] SETTLE_LAST = SEQ_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;

  logic [SYNC_STAGES-1:0] fab_sync;
  logic [SYNC_STAGES-1:0] mss_sync;
  logic                   lock_s;

  state_t            state;
  state_t            state_nx;
  logic [SEQ_W-1:0]  seq_cnt;
  logic [SEQ_W-1:0]  seq_cnt_nx;
  logic              fab_rst_n;
  logic              clk_ready;
  logic              lock_lost;
  logic              lock_lost_nx;
  logic [CNT_W-1:0]  loss_cnt;
  logic [CNT_W-1:0]  loss_cnt_nx;
  logic [CNT_W-1:0]  cnt_base;
  logic              loss_det;
  logic              loss_evt;

  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      fab_sync <= '0;
      mss_sync <= '0;
    end else begin
      fab_sync <= {fab_sync[SYNC_STAGES-2:0], bus.FAB_LOCK};
      mss_sync <= {mss_sync[SYNC_STAGES-2:0], bus.MSS_LOCK};
    end
  end

  assign lock_s = fab_sync[SYNC_STAGES-1] & mss_sync[SYNC_STAGES-1];

`ifdef CCC_LOCK_GLITCH_FILTER_EN
  localparam int LOW_W = $clog2(GLITCH_CYCLES + 1);
  localparam logic [LOW_W-1:0] LOW_LAST = LOW_W'(GLITCH_CYCLES - 1);

  logic [LOW_W-1:0] low_cnt;

  // Low-run counter only lives in RUN; any lock_s=1 or leaving RUN restarts it.
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      low_cnt <= '0;
    end else if (state_nx != ST_RUN || lock_s) begin
      low_cnt <= '0;
    end else begin
      low_cnt <= low_cnt + LOW_W'(1);
    end
  end

  assign loss_det = (state == ST_RUN) && !lock_s && (low_cnt == LOW_LAST);
`else
  assign loss_det = (state == ST_RUN) && !lock_s;
`endif

  // A soft reset takes priority, so a coincident loss is not recorded.
  assign loss_evt = loss_det & ~bus.SOFT_RST;

  always_comb begin
    state_nx   = state;
    seq_cnt_nx = seq_cnt;
    case (state)
      ST_HOLD: begin
        if (seq_cnt == HOLD_LAST) begin
          state_nx   = ST_WAIT;
          seq_cnt_nx = '0;
        end else begin
          seq_cnt_nx = seq_cnt + SEQ_W'(1);
        end
      end
      ST_WAIT: begin
        seq_cnt_nx = '0;
        if (lock_s) begin
          state_nx = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!lock_s) begin
          state_nx   = ST_WAIT;
          seq_cnt_nx = '0;
        end else if (seq_cnt == SETTLE_LAST) begin
          state_nx   = ST_RUN;
          seq_cnt_nx = '0;
        end else begin
          seq_cnt_nx = seq_cnt + SEQ_W'(1);
        end
      end
      ST_RUN: begin
        seq_cnt_nx = '0;
        if (loss_det) begin
          state_nx = ST_HOLD;
        end
      end
      default: begin
        state_nx   = ST_HOLD;
        seq_cnt_nx = '0;
      end
    endcase
    if (bus.SOFT_RST) begin
      state_nx   = ST_HOLD;
      seq_cnt_nx = '0;
    end
  end

  // A clear in the same cycle as a counted loss leaves exactly that one loss recorded.
  always_comb begin
    cnt_base    = bus.CLR_STATUS ? '0 : loss_cnt;
    loss_cnt_nx = cnt_base;
    if (loss_evt && cnt_base != CNT_SAT) begin
      loss_cnt_nx = cnt_base + CNT_W'(1);
    end
    lock_lost_nx = loss_evt | (lock_lost & ~bus.CLR_STATUS);
  end

  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      state     <= ST_HOLD;
      seq_cnt   <= '0;
      fab_rst_n <= 1'b0;
      clk_ready <= 1'b0;
      lock_lost <= 1'b0;
      loss_cnt  <= '0;
    end else begin
      state     <= state_nx;
      seq_cnt   <= seq_cnt_nx;
      fab_rst_n <= (state_nx == ST_RUN);
      clk_ready <= (state_nx == ST_RUN);
      lock_lost <= lock_lost_nx;
      loss_cnt  <= loss_cnt_nx;
    end
  end

  assign bus.FAB_RST_N = fab_rst_n;
  assign bus.CLK_READY = clk_ready;
  assign bus.LOCK_LOST = lock_lost;
  assign bus.LOSS_CNT  = loss_cnt;
  assign bus.DBG_STATE = state;

endmodule

// File: tb/tb_ccc_lock_reset_seq.sv
// Bench for ccc_lock_reset_seq: directed scenarios plus random lock dropouts against a rule-level reference model.
module tb_ccc_lock_reset_seq;

  localparam int SYNC_STAGES = 2;
  localparam int MIN_RST     = 4;
  localparam int LSC         = 8;
  localparam int GLITCH      = 4;
  localparam int CNT_W       = 2;
  localparam int EXP_W       = CNT_W + 3;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ccc_lock_reset_seq_if #(.CNT_W(CNT_W)) bus ();

  ccc_lock_reset_seq #(
    .SYNC_STAGES       (SYNC_STAGES),
    .MIN_RST_CYCLES    (MIN_RST),
    .LOCK_STABLE_CYCLES(LSC),
`ifdef CCC_LOCK_GLITCH_FILTER_EN
    .GLITCH_CYCLES     (GLITCH),
`endif
    .CNT_W             (CNT_W)
  ) dut (
    .FAB_CLK    (clk),
    .M2F_RESET_N(rst_n),
    .bus        (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Released once the minimum hold has elapsed and LSC+1 consecutive synchronized lock samples follow it.
  int   m_hold;
  int   m_stable;
  int   m_low;
  bit   m_run;
  bit   m_lost;
  int   m_cnt;
  bit   sync_q[$];
  logic [EXP_W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_restart();
    m_hold   = 0;
    m_stable = 0;
    m_low    = 0;
    m_run    = 1'b0;
  endtask

  task automatic model_reset();
    model_restart();
    m_lost = 1'b0;
    m_cnt  = 0;
    sync_q.delete();
    for (int i = 0; i < SYNC_STAGES; i++) sync_q.push_back(1'b0);
    exp_q.delete();
  endtask

  task automatic model_edge(input bit f, input bit m, input bit s, input bit c);
    bit ls;
    bit loss;
    ls = sync_q.pop_front();
    sync_q.push_back(f & m);
    loss = 1'b0;
    if (m_run && !ls) begin
      m_low++;
`ifdef CCC_LOCK_GLITCH_FILTER_EN
      loss = (m_low >= GLITCH);
`else
      loss = 1'b1;
`endif
    end
    if (s) begin
      model_restart();
    end else if (m_run) begin
      if (ls) m_low = 0;
      if (loss) model_restart();
    end else if (m_hold < MIN_RST) begin
      m_hold++;
    end else begin
      m_stable = ls ? m_stable + 1 : 0;
      if (m_stable == LSC + 1) m_run = 1'b1;
    end
    if (c) begin
      m_lost = 1'b0;
      m_cnt  = 0;
    end
    if (loss && !s) begin
      m_lost = 1'b1;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    exp_q.push_back({m_run, m_run, m_lost, CNT_W'(m_cnt)});
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: drive, let the posedge happen, then compare at the next negedge.
  task automatic step(input bit f, input bit m, input bit s, input bit c);
    logic [EXP_W-1:0] e;
    bus.FAB_LOCK   = f;
    bus.MSS_LOCK   = m;
    bus.SOFT_RST   = s;
    bus.CLR_STATUS = c;
    @(posedge clk);
    model_edge(f, m, s, c);
    @(negedge clk);
    e = exp_q.pop_front();
    check("fab_rst_n", 32'(bus.FAB_RST_N), 32'(e[EXP_W-1]));
    check("clk_ready", 32'(bus.CLK_READY), 32'(e[EXP_W-2]));
    check("lock_lost", 32'(bus.LOCK_LOST), 32'(e[EXP_W-3]));
    check("loss_cnt",  32'(bus.LOSS_CNT),  32'(e[CNT_W-1:0]));
  endtask

  task automatic run(input int n, input bit f, input bit m);
    for (int i = 0; i < n; i++) step(f, m, 1'b0, 1'b0);
  endtask

  // Asserted between edges; outputs must fall without waiting for a clock.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_fab_rst_n", 32'(bus.FAB_RST_N), 32'd0);
    check("rst_clk_ready", 32'(bus.CLK_READY), 32'd0);
    check("rst_lock_lost", 32'(bus.LOCK_LOST), 32'd0);
    check("rst_loss_cnt",  32'(bus.LOSS_CNT),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rel;
    bus.FAB_LOCK   = 1'b0;
    bus.MSS_LOCK   = 1'b0;
    bus.SOFT_RST   = 1'b0;
    bus.CLR_STATUS = 1'b0;
    @(negedge clk);

    // Locks already high when reset releases.
    bus.FAB_LOCK = 1'b1;
    bus.MSS_LOCK = 1'b1;
    apply_reset();
    rel = 0;
    for (int i = 1; i <= 25; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (bus.FAB_RST_N === 1'b1 && rel == 0) rel = i;
    end
    check("release_edge", 32'(rel), 32'(MIN_RST + 1 + LSC));

    // Lock arrives late, then drops for one cycle during the settle count.
    bus.FAB_LOCK = 1'b0;
    bus.MSS_LOCK = 1'b0;
    apply_reset();
    run(8, 1'b0, 1'b0);
    run(SYNC_STAGES + 1 + 5, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run(30, 1'b1, 1'b1);

    // Three-cycle MSS_LOCK drop while running.
    run(3, 1'b1, 1'b0);
    run(30, 1'b1, 1'b1);

    // Repeated losses saturate the counter.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      run(25, 1'b1, 1'b1);
    end
    check("loss_cnt_saturated", 32'(bus.LOSS_CNT), 32'(CNT_MAX));
    step(1'b1, 1'b1, 1'b0, 1'b1);
    run(3, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run(25, 1'b1, 1'b1);
    // Clear lands on the same edge as the loss.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    run(25, 1'b1, 1'b1);

    // Soft reset while running, then soft reset coincident with a loss.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    run(25, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    run(25, 1'b1, 1'b1);

    // Get some status set, then async reset in the middle of SETTLE.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run(25, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    run(MIN_RST + 3, 1'b1, 1'b1);
    apply_reset();
    run(20, 1'b1, 1'b1);

    // Short and long dropouts while running.
    run(3, 1'b0, 1'b1);
    run(15, 1'b1, 1'b1);
    run(4, 1'b0, 1'b1);
    run(30, 1'b1, 1'b1);

    // Random bursts: quiet blocks and noisy blocks with occasional strobes.
    for (int b = 0; b < 150; b++) begin
      int noise;
      noise = $urandom_range(0, 3);
      for (int i = 0; i < 20; i++) begin
        bit f;
        bit m;
        bit s;
        bit c;
        f = (noise == 0) ? 1'b1 : ($urandom_range(0, 7) != 0);
        m = (noise == 0) ? 1'b1 : ($urandom_range(0, 7) != 0);
        s = ($urandom_range(0, 99) == 0);
        c = ($urandom_range(0, 49) == 0);
        step(f, m, s, c);
      end
      if ($urandom_range(0, 49) == 0) apply_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
